// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count sequencer: run-control state encoding
// and a small helper for decoding the "busy" states.
package count_sequencer_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic is_active(input logic [1:0] s);
        return (s == S_RUN) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/count_datapath.sv
// WIDTH-bit count register with clear/load/increment controls and an
// equality compare against the terminal value for the sequencer FSM.
module count_datapath #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] q,
    output logic             at_term
);

    // clear outranks load, which outranks increment; the increment wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (inc) begin
            q <= q + 1'b1;
        end
    end

    assign at_term = (q == term_val);

endmodule

// File: rtl/count_sequencer.sv
// Run-control sequencer: FSM, operand/mode latches and registered
// start_ack/done pulses around a count_datapath instance.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic             start_ack,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] op_load, op_load_n;
    logic [WIDTH-1:0] op_term, op_term_n;
    logic             reload_mode, reload_mode_n;
    logic             ack_n, done_n;
    logic             dp_clear, dp_load, dp_inc, at_term;
    logic [WIDTH-1:0] dp_load_val;

    count_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .clear    (dp_clear),
        .load     (dp_load),
        .inc      (dp_inc),
        .load_val (dp_load_val),
        .term_val (op_term),
        .q        (q),
        .at_term  (at_term)
    );

    // Priority stop > start > hold > count; terminal test uses q before the edge
    always_comb begin
        state_n       = state;
        op_load_n     = op_load;
        op_term_n     = op_term;
        reload_mode_n = reload_mode;
        dp_clear      = 1'b0;
        dp_load       = 1'b0;
        dp_inc        = 1'b0;
        dp_load_val   = op_load;
        ack_n         = 1'b0;
        done_n        = 1'b0;
        if (stop) begin
            state_n  = S_IDLE;
            dp_clear = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_n       = S_RUN;
                        op_load_n     = load_val;
                        op_term_n     = term_val;
                        reload_mode_n = auto_reload;
                        dp_load       = 1'b1;
                        dp_load_val   = load_val;
                        ack_n         = 1'b1;
                    end
                end
                S_RUN: begin
                    if (hold) begin
                        state_n = S_HOLD;
                    end else if (at_term) begin
                        done_n = 1'b1;
                        if (reload_mode) begin
                            dp_load = 1'b1;
                        end else begin
                            state_n = S_DONE;
                        end
                    end else begin
                        dp_inc = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        state_n = S_RUN;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            op_load     <= '0;
            op_term     <= '0;
            reload_mode <= 1'b0;
            start_ack   <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            op_load     <= op_load_n;
            op_term     <= op_term_n;
            reload_mode <= reload_mode_n;
            start_ack   <= ack_n;
            done        <= done_n;
        end
    end

    assign busy = is_active(state);

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios with constant
// expectations plus a randomized run against a cycle-level behavioural model.
module tb_count_sequencer;

    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start, stop, hold, auto_reload;
    logic [WIDTH-1:0] load_val, term_val;
    logic             start_ack, busy, done;
    logic [WIDTH-1:0] q;

    int checks = 0;
    int errors = 0;

    int m_mode, m_q, m_load, m_term;
    bit m_reload, m_done, m_ack;

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .term_val    (term_val),
        .start_ack   (start_ack),
        .q           (q),
        .busy        (busy),
        .done        (done)
    );

    task automatic model_reset();
        m_mode = M_IDLE; m_q = 0; m_load = 0; m_term = 0;
        m_reload = 0; m_done = 0; m_ack = 0;
    endtask

    // One clock of the sequencer as described by its command rules
    task automatic model_step();
        m_done = 0;
        m_ack  = 0;
        if (stop) begin
            m_mode = M_IDLE;
            m_q    = 0;
        end else if ((m_mode == M_IDLE || m_mode == M_DONE) && start) begin
            m_q = int'(load_val); m_load = int'(load_val); m_term = int'(term_val);
            m_reload = auto_reload; m_ack = 1; m_mode = M_RUN;
        end else if (m_mode == M_HOLD) begin
            if (!hold) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (hold) begin
                m_mode = M_HOLD;
            end else if (m_q == m_term) begin
                m_done = 1;
                if (m_reload) m_q = m_load;
                else m_mode = M_DONE;
            end else begin
                m_q = (m_q + 1) % MOD;
            end
        end
    endtask

    task automatic tick();
        if (reset) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; hold = 0; auto_reload = 0; load_val = '0; term_val = '0;
    endtask

    task automatic go(input int ld, input int tm, input bit rl);
        start = 1; load_val = WIDTH'(ld); term_val = WIDTH'(tm); auto_reload = rl;
        tick();
        start = 0;
    endtask

    task automatic go_idle();
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        model_reset();
        tick(); tick();
        checks++;
        if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || start_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_initial got q=%0d busy=%b done=%b ack=%b want 0 0 0 0", q, busy, done, start_ack);
        end
        reset = 1;
        tick();
        go(3, 12, 0);
        tick(); tick();
        checks++;
        if (q !== 4'd5) begin
            errors++;
            $display("[TB] FAIL reset_precount got q=%0d want 5", q);
        end
        #2;
        reset = 0;
        model_reset();
        #1;
        checks++;
        if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || start_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async got q=%0d busy=%b done=%b ack=%b want 0 0 0 0", q, busy, done, start_ack);
        end
        tick();
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== '0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d got q=%0d busy=%b want 0 0", i, q, busy);
            end
        end
    endtask

    task automatic test_oneshot();
        go(2, 5, 0);
        checks++;
        if (start_ack !== 1'b1 || q !== 4'd2 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oneshot_accept got ack=%b q=%0d busy=%b want 1 2 1", start_ack, q, busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== WIDTH'(3 + i) || done !== 1'b0 || busy !== 1'b1 || start_ack !== 1'b0) begin
                errors++;
                $display("[TB] FAIL oneshot_count step %0d got q=%0d done=%b busy=%b ack=%b want %0d 0 1 0",
                         i, q, done, busy, start_ack, 3 + i);
            end
        end
        tick();
        checks++;
        if (q !== 4'd5 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oneshot_done got q=%0d done=%b busy=%b want 5 1 0", q, done, busy);
        end
        tick();
        checks++;
        if (q !== 4'd5 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oneshot_after got q=%0d done=%b busy=%b want 5 0 0", q, done, busy);
        end
        go_idle();
    endtask

    task automatic test_reload();
        int seq [4] = '{14, 15, 0, 1};
        go(14, 1, 1);
        checks++;
        if (q !== 4'd14 || start_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reload_accept got q=%0d ack=%b want 14 1", q, start_ack);
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (q !== WIDTH'(seq[i % 4]) || done !== (i % 4 == 0) || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reload_cycle %0d got q=%0d done=%b busy=%b want %0d %0d 1",
                         i, q, done, busy, seq[i % 4], (i % 4 == 0));
            end
        end
        go_idle();
        checks++;
        if (q !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reload_stop got q=%0d busy=%b done=%b want 0 0 0", q, busy, done);
        end
    endtask

    // Two hold edges plus the non-counting resume edge delay done by three cycles
    task automatic test_hold();
        int exp_q [7] = '{3, 3, 3, 3, 4, 5, 5};
        go(2, 5, 0);
        for (int i = 0; i < 7; i++) begin
            hold = (i == 1 || i == 2);
            tick();
            checks++;
            if (q !== WIDTH'(exp_q[i]) || busy !== (i < 6) || done !== (i == 6)) begin
                errors++;
                $display("[TB] FAIL hold_cycle %0d got q=%0d busy=%b done=%b want %0d %0d %0d",
                         i, q, busy, done, exp_q[i], (i < 6), (i == 6));
            end
        end
        hold = 0;
        go_idle();
    endtask

    task automatic test_stop();
        go(0, 3, 0);
        tick(); tick(); tick();
        checks++;
        if (q !== 4'd3 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stop_preterm got q=%0d busy=%b want 3 1", q, busy);
        end
        go_idle();
        checks++;
        if (q !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_at_term got q=%0d busy=%b done=%b want 0 0 0", q, busy, done);
        end
        start = 1; stop = 1; load_val = 4'd6; term_val = 4'd9;
        tick();
        start = 0; stop = 0;
        checks++;
        if (start_ack !== 1'b0 || busy !== 1'b0 || q !== '0) begin
            errors++;
            $display("[TB] FAIL stop_with_start got ack=%b busy=%b q=%0d want 0 0 0", start_ack, busy, q);
        end
    endtask

    task automatic test_back_to_back();
        go(7, 7, 0);
        checks++;
        if (start_ack !== 1'b1 || q !== 4'd7 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL equal_accept got ack=%b q=%0d busy=%b want 1 7 1", start_ack, q, busy);
        end
        start = 1; load_val = 4'd1; term_val = 4'd2;
        tick();
        checks++;
        if (start_ack !== 1'b0 || done !== 1'b1 || q !== 4'd7 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL equal_done got ack=%b done=%b q=%0d busy=%b want 0 1 7 0", start_ack, done, q, busy);
        end
        load_val = 4'd9; term_val = 4'd10;
        tick();
        start = 0;
        checks++;
        if (start_ack !== 1'b1 || q !== 4'd9 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rerun_accept got ack=%b q=%0d busy=%b done=%b want 1 9 1 0", start_ack, q, busy, done);
        end
        tick(); tick();
        checks++;
        if (q !== 4'd10 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rerun_done got q=%0d done=%b busy=%b want 10 1 0", q, done, busy);
        end
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            stop        = ($urandom_range(0, 39) == 0);
            start       = ($urandom_range(0, 5) == 0);
            hold        = ($urandom_range(0, 4) == 0);
            auto_reload = $urandom_range(0, 1);
            load_val    = WIDTH'($urandom_range(0, MOD - 1));
            term_val    = WIDTH'($urandom_range(0, MOD - 1));
            tick();
            checks++;
            if (q !== WIDTH'(m_q) || busy !== (m_mode == M_RUN || m_mode == M_HOLD) ||
                done !== m_done || start_ack !== m_ack) begin
                errors++;
                $display("[TB] FAIL random cycle %0d got q=%0d busy=%b done=%b ack=%b want %0d %0d %0d %0d",
                         i, q, busy, done, start_ack, m_q, (m_mode == M_RUN || m_mode == M_HOLD), m_done, m_ack);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_hold();
        test_stop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
